// File: rtl/ethernet_reply_tx_arbiter.sv
// Arbitrates ARP and ICMP reply transmitters onto one byte stream toward the MAC,
// with round-robin grant, start timeout and an enforced inter-frame gap.
module ethernet_reply_tx_arbiter #(
   parameter int IFG_CYCLES    = 12,
   parameter int START_TIMEOUT = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_arp_req,
   input  logic       i_icmp_req,
   output logic       o_arp_start,
   output logic       o_icmp_start,
   input  logic [7:0] i_arp_word,
   input  logic       i_arp_valid,
   input  logic [7:0] i_icmp_word,
   input  logic       i_icmp_valid,
   output logic [7:0] o_word,
   output logic       o_valid,
   output logic       o_busy,
   output logic       o_err_timeout
);

   localparam int CNT_MAX = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // state        | meaning
   // S_IDLE       | no grant; pick a pending source
   // S_START      | one-cycle start pulse to the granted transmitter
   // S_WAIT_VALID | waiting for the first byte, bounded by START_TIMEOUT
   // S_SEND       | forwarding granted bytes until valid drops
   // S_GAP        | inter-frame gap of IFG_CYCLES cycles
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_VALID,
      S_SEND,
      S_GAP
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_pend_arp;
   logic             r_pend_icmp;
   logic             r_sel_icmp;
   logic             w_sel_icmp_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_word;
   logic             r_valid;
   logic             w_sel_valid;
   logic [7:0]       w_sel_word;
   logic             w_err;
   logic             w_start_done;

   always_comb begin
      w_state_nxt    = r_state;
      w_sel_icmp_nxt = r_sel_icmp;
      w_err          = 1'b0;
      w_sel_valid    = r_sel_icmp ? i_icmp_valid : i_arp_valid;
      w_sel_word     = r_sel_icmp ? i_icmp_word  : i_arp_word;
      case (r_state)
         S_IDLE: begin
            if (r_pend_arp || r_pend_icmp) begin
               w_state_nxt = S_START;
               // r_sel_icmp still names the last served source, so a tie goes to the other one
               w_sel_icmp_nxt = r_pend_icmp && (!r_pend_arp || !r_sel_icmp);
            end
         end
         S_START:      w_state_nxt = S_WAIT_VALID;
         S_WAIT_VALID: begin
            if (w_sel_valid) begin
               w_state_nxt = S_SEND;
            end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
               w_err       = 1'b1;
               w_state_nxt = S_GAP;
            end
         end
         S_SEND: begin
            if (!w_sel_valid) w_state_nxt = S_GAP;
         end
         S_GAP: begin
            if (r_cnt == CNT_W'(IFG_CYCLES - 1)) w_state_nxt = S_IDLE;
         end
         default:      w_state_nxt = S_IDLE;
      endcase
   end

   assign w_start_done = (r_state == S_START);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_pend_arp  <= 1'b0;
         r_pend_icmp <= 1'b0;
         r_sel_icmp  <= 1'b1;  // "ICMP served last" so ARP wins the first tie
         r_cnt       <= '0;
         r_word      <= 8'h00;
         r_valid     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sel_icmp  <= w_sel_icmp_nxt;
         r_pend_arp  <= i_arp_req  | (r_pend_arp  & ~(w_start_done & ~r_sel_icmp));
         r_pend_icmp <= i_icmp_req | (r_pend_icmp & ~(w_start_done &  r_sel_icmp));
         if (w_state_nxt != r_state) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT_VALID || r_state == S_GAP) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == S_WAIT_VALID || r_state == S_SEND) begin
            r_word  <= w_sel_word;
            r_valid <= w_sel_valid;
         end else begin
            r_word  <= 8'h00;
            r_valid <= 1'b0;
         end
      end
   end

   assign o_arp_start   = w_start_done & ~r_sel_icmp;
   assign o_icmp_start  = w_start_done &  r_sel_icmp;
   assign o_word        = r_word;
   assign o_valid       = r_valid;
   assign o_busy        = (r_state != S_IDLE);
   assign o_err_timeout = w_err;

endmodule

// File: tb/tb_ethernet_reply_tx_arbiter.sv
// Randomized bench for ethernet_reply_tx_arbiter: emulates both reply transmitters and predicts
// every output per cycle from a frame-schedule model (start cycle, first byte, length, gap).
module tb_ethernet_reply_tx_arbiter;

   localparam int IFG = 12;
   localparam int TO  = 4;

   logic       clk = 1'b0;
   logic       i_reset, i_arp_req, i_icmp_req;
   logic       o_arp_start, o_icmp_start;
   logic [7:0] i_arp_word, i_icmp_word, o_word;
   logic       i_arp_valid, i_icmp_valid, o_valid, o_busy, o_err_timeout;

   always #5 clk = ~clk;

   ethernet_reply_tx_arbiter #(.IFG_CYCLES(IFG), .START_TIMEOUT(TO)) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_arp_req    (i_arp_req),
      .i_icmp_req   (i_icmp_req),
      .o_arp_start  (o_arp_start),
      .o_icmp_start (o_icmp_start),
      .i_arp_word   (i_arp_word),
      .i_arp_valid  (i_arp_valid),
      .i_icmp_word  (i_icmp_word),
      .i_icmp_valid (i_icmp_valid),
      .o_word       (o_word),
      .o_valid      (o_valid),
      .o_busy       (o_busy),
      .o_err_timeout(o_err_timeout)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // frame schedule model: source 0 = ARP, 1 = ICMP
   bit         pend[2];
   bit         last_icmp;
   bit         g;
   int         g_src, g_c, g_d, g_l, g_idle;
   logic [7:0] g_bytes[64];
   int         fp_d = -1;
   int         fp_l = -1;
   bit         q_arp, q_icmp, q_rst;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      bit         rq[2];
      bit         tv[2];
      logic [7:0] tw[2];
      bit         e_start[2];
      bit         e_busy, e_err, e_valid;
      logic [7:0] e_word;
      int         idx;
      @(negedge clk);
      if (g && cyc >= g_idle) g = 1'b0;
      if (!g && (pend[0] || pend[1])) begin
         g         = 1'b1;
         g_src     = (pend[0] && pend[1]) ? (last_icmp ? 0 : 1) : (pend[0] ? 0 : 1);
         last_icmp = (g_src == 1);
         g_c       = cyc + 1;
         g_d       = (fp_d >= 0) ? fp_d : $urandom_range(1, 6);
         if (g_d > TO) g_l = 0;
         else          g_l = (fp_l >= 0) ? fp_l : $urandom_range(1, 20);
         fp_d = -1;
         fp_l = -1;
         for (int k = 0; k < 64; k++) g_bytes[k] = 8'($urandom);
         g_idle = (g_d <= TO) ? (g_c + g_d + g_l + 1 + IFG) : (g_c + TO + 1 + IFG);
      end
      for (int s = 0; s < 2; s++) begin
         if (g && g_src == s) begin
            idx   = cyc - g_c - g_d;
            tv[s] = (g_d <= TO) && idx >= 0 && idx < g_l;
            tw[s] = tv[s] ? g_bytes[idx] : 8'h00;
         end else begin
            tv[s] = 1'($urandom_range(0, 1));
            tw[s] = 8'($urandom);
         end
      end
      rq[0] = q_arp;
      rq[1] = q_icmp;
      i_reset      = q_rst;
      i_arp_req    = rq[0];
      i_icmp_req   = rq[1];
      i_arp_valid  = tv[0];
      i_arp_word   = tw[0];
      i_icmp_valid = tv[1];
      i_icmp_word  = tw[1];

      e_start[0] = g && g_src == 0 && cyc == g_c;
      e_start[1] = g && g_src == 1 && cyc == g_c;
      e_busy     = g && cyc >= g_c && cyc < g_idle;
      e_err      = g && g_d > TO && cyc == g_c + TO;
      idx        = cyc - g_c - g_d - 1;
      e_valid    = g && g_d <= TO && idx >= 0 && idx < g_l;
      e_word     = e_valid ? g_bytes[idx] : 8'h00;
      #1;
      check_eq("arp_start",  32'(o_arp_start),   32'(e_start[0]));
      check_eq("icmp_start", 32'(o_icmp_start),  32'(e_start[1]));
      check_eq("busy",       32'(o_busy),        32'(e_busy));
      check_eq("err_timeout",32'(o_err_timeout), 32'(e_err));
      check_eq("valid",      32'(o_valid),       32'(e_valid));
      check_eq("word",       32'(o_word),        32'(e_word));

      if (q_rst) begin
         g         = 1'b0;
         pend[0]   = 1'b0;
         pend[1]   = 1'b0;
         last_icmp = 1'b1;
      end else begin
         for (int s = 0; s < 2; s++)
            pend[s] = rq[s] | (pend[s] & !(g && g_src == s && cyc == g_c));
      end
      q_arp  = 1'b0;
      q_icmp = 1'b0;
      q_rst  = 1'b0;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      q_rst = 1'b1;
      step();
   endtask

   initial begin
      i_reset = 1'b1;
      {i_arp_req, i_icmp_req, i_arp_valid, i_icmp_valid} = '0;
      i_arp_word  = 8'h00;
      i_icmp_word = 8'h00;
      g = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0; last_icmp = 1'b1;
      q_arp = 1'b0; q_icmp = 1'b0; q_rst = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();

      // single ARP frame of 54 bytes, first byte one cycle after start
      fp_d = 1; fp_l = 54;
      q_arp = 1'b1; step();
      run(80);

      // simultaneous requests right after reset: ARP first
      do_reset();
      q_arp = 1'b1; q_icmp = 1'b1; step();
      run(140);

      // ARP re-requested during its own frame while ICMP waits: ICMP next, then ARP
      do_reset();
      fp_d = 1; fp_l = 30;
      q_arp = 1'b1; step();
      run(8);
      q_icmp = 1'b1; step();
      run(6);
      q_arp = 1'b1; step();
      run(200);

      // silent ICMP transmitter: timeout path
      do_reset();
      fp_d = 99;
      q_icmp = 1'b1; step();
      run(30);

      // reset around byte 20 of an ARP frame, then a fresh ICMP request
      do_reset();
      fp_d = 1; fp_l = 54;
      q_arp = 1'b1; step();
      run(23);
      do_reset();
      run(2);
      q_icmp = 1'b1; step();
      run(60);

      // random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         q_arp  = ($urandom_range(0, 19) == 0);
         q_icmp = ($urandom_range(0, 19) == 0);
         q_rst  = ($urandom_range(0, 599) == 0);
         step();
      end
      run(80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ethernet_reply_tx_arbiter.md
ETHERNET_REPLY_TX_ARBITER -- requirements
Module: ethernet_reply_tx_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, default 12, idle cycles enforced between frames on the shared byte stream.
REQ-002 Parameter START_TIMEOUT, default 4, maximum cycles from start pulse to the first valid byte of the granted transmitter.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_arp_req  input  1  one-cycle request pulse: an ARP reply is ready to send.
REQ-006 i_icmp_req  input  1  one-cycle request pulse: an ICMP reply is ready to send.
REQ-007 o_arp_start  output  1  one-cycle start pulse to the ARP reply transmitter (its ready input).
REQ-008 o_icmp_start  output  1  one-cycle start pulse to the ICMP reply transmitter.
REQ-009 i_arp_word / i_arp_valid  input  8 / 1  ARP transmitter byte stream.
REQ-010 i_icmp_word / i_icmp_valid  input  8 / 1  ICMP transmitter byte stream.
REQ-011 o_word / o_valid  output  8 / 1  shared serial byte stream toward the MAC.
REQ-012 o_busy  output  1  high whenever the FSM is not IDLE.
REQ-013 o_err_timeout  output  1  one-cycle pulse: the granted transmitter failed to start.

Function
REQ-014 Each request pulse SHALL set a pending bit for its source at the sampling edge; a second pulse while pending SHALL be absorbed (no count).
REQ-015 FSM states SHALL be IDLE, START, WAIT_VALID, SEND, GAP.
REQ-016 In IDLE with any pending bit set, the FSM SHALL select one source and go to START at the next edge. The selection is round-robin: the source not served last wins a tie, and ARP wins the first tie after reset.
REQ-017 In START, the selected start output SHALL be high for exactly that one cycle; its pending bit SHALL clear at the same edge; the FSM SHALL then enter WAIT_VALID.
REQ-018 A request pulse for a source coinciding with its pending-bit clear SHALL leave the bit set (set wins).
REQ-019 In WAIT_VALID, the FSM SHALL enter SEND when the selected valid is high; if START_TIMEOUT cycles elapse without it, the FSM SHALL pulse o_err_timeout and enter GAP.
REQ-020 In SEND, the FSM SHALL enter GAP on the first cycle the selected valid is low.
REQ-021 In GAP, the FSM SHALL hold for IFG_CYCLES cycles, counted from GAP entry, then return to IDLE.
REQ-022 o_word/o_valid SHALL be registered copies of the selected source's word/valid, one-cycle latency, only while in WAIT_VALID or SEND; otherwise both SHALL be 0.
REQ-023 The non-selected stream SHALL never reach o_word/o_valid, even if its valid is asserted.
REQ-024 Counters SHALL be sized to hold max(IFG_CYCLES, START_TIMEOUT) without wrap and SHALL clear on every state entry.
REQ-025 Request to start latency SHALL be 2 edges when idle: the request is sampled at edge N, and the start pulse is high between edges N+1 and N+2.

Reset
REQ-026 While i_reset is high at an edge, the block SHALL set: FSM=IDLE, pending bits=0, round-robin pointer=ARP-first, counters=0, o_word=0, o_valid=0, o_arp_start=0, o_icmp_start=0, o_busy=0, o_err_timeout=0.
REQ-027 Reset asserted mid-frame SHALL abort immediately: o_valid=0 after the edge; the remaining transmitter bytes SHALL be ignored.

Verification
REQ-028 ARP pulse only, transmitter emits 54 bytes starting 1 cycle after start -> one o_arp_start pulse; 54 o_valid cycles with bytes in order, each 1 cycle delayed; then o_busy high for exactly 12 more cycles.
REQ-029 ARP and ICMP pulses on the same edge after reset -> ARP served first; ICMP start pulse 1 cycle after ARP's GAP ends; no overlap of valids.
REQ-030 Second ARP pulse during the ARP SEND while ICMP is also pending -> ICMP is served next (round-robin), then ARP.
REQ-031 ICMP start with transmitter silent -> o_err_timeout pulses 4 cycles after start; GAP of 12 cycles; return to IDLE; o_valid stays 0.
REQ-032 i_icmp_valid forced high during an ARP frame -> o_word carries only ARP bytes.
REQ-033 Reset at byte 20 of an ARP frame -> all outputs 0 on the next cycle; a fresh ICMP pulse afterwards is served with 2-edge latency.
